// File: rtl/range_pkg.sv
// Shared class encoding, range boundaries and scan FSM states for the range scanner.
package range_pkg;

  typedef enum logic [1:0] {
    CLS_LOW   = 2'd0,
    CLS_MID   = 2'd1,
    CLS_HIGH  = 2'd2,
    CLS_INVAL = 2'd3
  } cls_t;

  localparam logic [3:0] LOW_MAX  = 4'd3;
  localparam logic [3:0] MID_MAX  = 4'd6;
  localparam logic [3:0] HIGH_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/range_decode.sv
// Combinational 4-bit code to range class; zero latency, no flow control.
module range_decode
  import range_pkg::*;
(
  input  logic [3:0] code,
  output cls_t       cls
);

  always_comb begin
    cls = CLS_INVAL;
    if (code <= LOW_MAX)       cls = CLS_LOW;
    else if (code <= MID_MAX)  cls = CLS_MID;
    else if (code <= HIGH_MAX) cls = CLS_HIGH;
  end

endmodule

// File: rtl/range_scan_ctrl.sv
// Scans a snapshot of NUM_CH codes through one shared decoder, one result per 1+HOLD_CYCLES cycles.
// Results are registered (visible the cycle after SCAN); start is only taken in IDLE, abort wins over everything but rst.
module range_scan_ctrl
  import range_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic                                          clr_cnt,
  input  logic [4*NUM_CH-1:0]                           ch_codes,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          cls_valid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cls_ch,
  output logic                                          cout1,
  output logic                                          cout2,
  output logic                                          cout3,
  output logic [CNT_W-1:0]                              cnt_low,
  output logic [CNT_W-1:0]                              cnt_mid,
  output logic [CNT_W-1:0]                              cnt_high,
  output logic [CNT_W-1:0]                              cnt_inval
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t                   state;
  logic [NUM_CH-1:0][3:0]   snap;
  logic [CH_W-1:0]          idx;
  logic [HC_W-1:0]          hold_cnt;
  logic [CNT_W-1:0]         cnt [4];
  cls_t                     cls;
  logic                     last_ch;
  logic                     hit;

  range_decode u_dec (
    .code (snap[idx]),
    .cls  (cls)
  );

  assign last_ch = (idx == CH_W'(NUM_CH - 1));
  // An abort landing on the SCAN cycle discards that classification entirely.
  assign hit     = (state == ST_SCAN) && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      snap      <= '0;
      idx       <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cls_valid <= 1'b0;
      cls_ch    <= '0;
      cout1     <= 1'b0;
      cout2     <= 1'b0;
      cout3     <= 1'b0;
    end else begin
      cls_valid <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        if (state != ST_IDLE) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          cout1 <= 1'b0;
          cout2 <= 1'b0;
          cout3 <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              snap  <= ch_codes;
              idx   <= '0;
              cout1 <= 1'b0;
              cout2 <= 1'b0;
              cout3 <= 1'b0;
              busy  <= 1'b1;
              state <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            cout1     <= (cls == CLS_LOW);
            cout2     <= (cls == CLS_MID);
            cout3     <= (cls == CLS_HIGH);
            cls_ch    <= idx;
            cls_valid <= 1'b1;
            hold_cnt  <= HC_W'(HOLD_CYCLES - 1);
            state     <= ST_HOLD;
          end
          ST_HOLD: begin
            if (hold_cnt == '0) begin
              if (last_ch) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                idx   <= idx + CH_W'(1);
                state <= ST_SCAN;
              end
            end else begin
              hold_cnt <= hold_cnt - HC_W'(1);
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Counters accumulate across runs; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (hit && (cnt[cls] != '1)) begin
      cnt[cls] <= cnt[cls] + CNT_W'(1);
    end
  end

  assign cnt_low   = cnt[CLS_LOW];
  assign cnt_mid   = cnt[CLS_MID];
  assign cnt_high  = cnt[CLS_HIGH];
  assign cnt_inval = cnt[CLS_INVAL];

endmodule

// File: tb/tb_range_scan_ctrl.sv
// Bench for range_scan_ctrl: default instance plus a small saturating-counter instance.
module tb_range_scan_ctrl;

  localparam int NCH = 4;
  localparam int HC  = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort, clr_cnt;
  logic [15:0] ch_codes;
  logic        busy, done, cls_valid, cout1, cout2, cout3;
  logic [1:0]  cls_ch;
  logic [7:0]  cnt_low, cnt_mid, cnt_high, cnt_inval;

  logic        s_rst, s_start, s_abort, s_clr;
  logic [7:0]  s_codes;
  logic        s_busy, s_done, s_cls_valid, s_cout1, s_cout2, s_cout3;
  logic [0:0]  s_cls_ch;
  logic [1:0]  s_cnt_low, s_cnt_mid, s_cnt_high, s_cnt_inval;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_cnt [4];

  always #5 clk = ~clk;

  range_scan_ctrl #(.NUM_CH(NCH), .HOLD_CYCLES(HC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .clr_cnt(clr_cnt),
    .ch_codes(ch_codes), .busy(busy), .done(done), .cls_valid(cls_valid),
    .cls_ch(cls_ch), .cout1(cout1), .cout2(cout2), .cout3(cout3),
    .cnt_low(cnt_low), .cnt_mid(cnt_mid), .cnt_high(cnt_high), .cnt_inval(cnt_inval)
  );

  range_scan_ctrl #(.NUM_CH(2), .HOLD_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(s_rst), .start(s_start), .abort(s_abort), .clr_cnt(s_clr),
    .ch_codes(s_codes), .busy(s_busy), .done(s_done), .cls_valid(s_cls_valid),
    .cls_ch(s_cls_ch), .cout1(s_cout1), .cout2(s_cout2), .cout3(s_cout3),
    .cnt_low(s_cnt_low), .cnt_mid(s_cnt_mid), .cnt_high(s_cnt_high), .cnt_inval(s_cnt_inval)
  );

  // Reference classification straight from the range table: {HIGH, MID, LOW}.
  function automatic logic [2:0] onehot(input logic [3:0] v);
    if (v <= 4'd3) return 3'b001;
    if (v <= 4'd6) return 3'b010;
    if (v <= 4'd9) return 3'b100;
    return 3'b000;
  endfunction

  function automatic int cls_idx(input logic [3:0] v);
    if (v <= 4'd3) return 0;
    if (v <= 4'd6) return 1;
    if (v <= 4'd9) return 2;
    return 3;
  endfunction

  // One complete run from a start accepted at edge 0, checked cycle by cycle against the timing rules.
  task automatic run_scan(input logic [15:0] codes, input bit scramble, input int abort_cyc,
                          input bit hold_start);
    int         done_c, end_c, k;
    logic [2:0] e_cout;
    logic       e_vld, e_done, e_busy;
    bit         aborted;
    done_c = NCH * (1 + HC) + 1;
    end_c  = (abort_cyc > 0) ? abort_cyc + 3 : done_c + 2;
    @(posedge clk); #1;
    ch_codes = codes; start = 1'b1; abort = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= end_c; c++) begin
      #1;
      start = hold_start && (c <= done_c);
      abort = (c == abort_cyc);
      if (scramble) ch_codes = 16'($urandom);
      @(negedge clk);
      aborted = (abort_cyc > 0) && (c > abort_cyc);
      k = (c < 2) ? 0 : (c - 2) / (1 + HC);
      if (k > NCH - 1) k = NCH - 1;
      e_vld  = !aborted && (c >= 2) && (c < 2 + NCH * (1 + HC)) && (((c - 2) % (1 + HC)) == 0);
      e_done = !aborted && (c == done_c);
      e_busy = !aborted && (c <= done_c);
      e_cout = (aborted || c < 2) ? 3'b000 : onehot(codes[4*k +: 4]);
      if (e_vld && m_cnt[cls_idx(codes[4*k +: 4])] < 255) m_cnt[cls_idx(codes[4*k +: 4])]++;
      n_cmp++; if (busy !== e_busy) begin n_fail++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy, e_busy); end
      n_cmp++; if (done !== e_done) begin n_fail++; $display("FAIL done c=%0d got=%b exp=%b", c, done, e_done); end
      n_cmp++; if (cls_valid !== e_vld) begin n_fail++; $display("FAIL cls_valid c=%0d got=%b exp=%b", c, cls_valid, e_vld); end
      n_cmp++; if ({cout3, cout2, cout1} !== e_cout) begin n_fail++; $display("FAIL cout c=%0d got=%b exp=%b", c, {cout3, cout2, cout1}, e_cout); end
      if (!aborted && c >= 2) begin
        n_cmp++; if (cls_ch !== 2'(k)) begin n_fail++; $display("FAIL cls_ch c=%0d got=%0d exp=%0d", c, cls_ch, k); end
      end
      n_cmp++; if (cnt_low !== 8'(m_cnt[0])) begin n_fail++; $display("FAIL cnt_low c=%0d got=%0d exp=%0d", c, cnt_low, m_cnt[0]); end
      n_cmp++; if (cnt_mid !== 8'(m_cnt[1])) begin n_fail++; $display("FAIL cnt_mid c=%0d got=%0d exp=%0d", c, cnt_mid, m_cnt[1]); end
      n_cmp++; if (cnt_high !== 8'(m_cnt[2])) begin n_fail++; $display("FAIL cnt_high c=%0d got=%0d exp=%0d", c, cnt_high, m_cnt[2]); end
      n_cmp++; if (cnt_inval !== 8'(m_cnt[3])) begin n_fail++; $display("FAIL cnt_inval c=%0d got=%0d exp=%0d", c, cnt_inval, m_cnt[3]); end
      @(posedge clk);
    end
    #1; start = 1'b0; abort = 1'b0;
  endtask

  task automatic clear_counters();
    @(posedge clk); #1; clr_cnt = 1'b1;
    @(posedge clk); #1; clr_cnt = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    n_cmp++; if ({cnt_low, cnt_mid, cnt_high, cnt_inval} !== 32'd0) begin
      n_fail++; $display("FAIL clr_cnt got=%h exp=0", {cnt_low, cnt_mid, cnt_high, cnt_inval});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1; start = 1'b1; abort = 1'b0; clr_cnt = 1'b0; ch_codes = 16'($urandom);
    s_start = 1'b1; s_abort = 1'b0; s_clr = 1'b0; s_codes = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, done, cls_valid, cls_ch, cout3, cout2, cout1} !== 8'd0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {busy, done, cls_valid, cls_ch, cout3, cout2, cout1});
    end
    n_cmp++; if ({cnt_low, cnt_mid, cnt_high, cnt_inval} !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt got=%h exp=0", {cnt_low, cnt_mid, cnt_high, cnt_inval});
    end
    n_cmp++; if ({s_busy, s_done, s_cnt_low} !== 4'd0) begin
      n_fail++; $display("FAIL reset_sat got=%b exp=0", {s_busy, s_done, s_cnt_low});
    end
    @(posedge clk); #1;
    rst = 1'b0; s_rst = 1'b0; start = 1'b0; s_start = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic test_directed();
    clear_counters();
    run_scan(16'h963C, 1'b0, 0, 1'b0);
    n_cmp++; if ({cnt_low, cnt_mid, cnt_high, cnt_inval} !== {8'd1, 8'd1, 8'd1, 8'd1}) begin
      n_fail++; $display("FAIL directed_cnts got=%h exp=01010101", {cnt_low, cnt_mid, cnt_high, cnt_inval});
    end
  endtask

  task automatic test_boundary();
    logic [15:0] codes;
    clear_counters();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) codes[4*i +: 4] = 4'(4 * r + i);
      run_scan(codes, 1'b0, 0, 1'b0);
    end
    n_cmp++; if ({cnt_low, cnt_mid, cnt_high, cnt_inval} !== {8'd4, 8'd3, 8'd3, 8'd6}) begin
      n_fail++; $display("FAIL boundary_cnts got=%h exp=04030306", {cnt_low, cnt_mid, cnt_high, cnt_inval});
    end
  endtask

  task automatic test_snapshot();
    for (int r = 0; r < 3; r++) run_scan(16'($urandom), 1'b1, 0, 1'b0);
  endtask

  task automatic test_abort();
    clear_counters();
    run_scan(16'h0000, 1'b0, 12, 1'b0);
    n_cmp++; if (cnt_low !== 8'd2) begin n_fail++; $display("FAIL abort_cnt got=%0d exp=2", cnt_low); end
    run_scan(16'($urandom), 1'b0, 1 + $urandom_range(0, 30), 1'b0);
    // abort together with start in IDLE: start must not be taken
    @(posedge clk); #1; start = 1'b1; abort = 1'b1; ch_codes = 16'($urandom);
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle busy got=%b exp=0", busy); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (cls_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle cls_valid got=%b exp=0", cls_valid); end
  endtask

  task automatic test_start_held();
    run_scan(16'($urandom), 1'b0, 0, 1'b1);
    run_scan(16'($urandom), 1'b0, 0, 1'b0);
  endtask

  task automatic test_rst_mid();
    @(posedge clk); #1; start = 1'b1; ch_codes = 16'($urandom);
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    n_cmp++; if ({busy, done, cls_valid, cls_ch, cout3, cout2, cout1} !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid_ctrl got=%b exp=0", {busy, done, cls_valid, cls_ch, cout3, cout2, cout1});
    end
    n_cmp++; if ({cnt_low, cnt_mid, cnt_high, cnt_inval} !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_cnt got=%h exp=0", {cnt_low, cnt_mid, cnt_high, cnt_inval});
    end
    run_scan(16'($urandom), 1'b0, 0, 1'b0);
  endtask

  task automatic sat_wait_done();
    int t = 0;
    while (!s_done && t < 50) begin @(posedge clk); #1; t++; end
    n_cmp++; if (t >= 50) begin n_fail++; $display("FAIL sat_done_timeout got=%0d cycles exp<50", t); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int exp_low;
    for (int r = 1; r <= 5; r++) begin
      @(posedge clk); #1; s_start = 1'b1; s_codes = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      @(posedge clk); #1; s_start = 1'b0;
      sat_wait_done();
      exp_low = (2 * r > 3) ? 3 : 2 * r;
      n_cmp++; if (s_cnt_low !== 2'(exp_low)) begin n_fail++; $display("FAIL sat_cnt run=%0d got=%0d exp=%0d", r, s_cnt_low, exp_low); end
    end
    n_cmp++; if ({s_cnt_mid, s_cnt_high, s_cnt_inval} !== 6'd0) begin
      n_fail++; $display("FAIL sat_other got=%b exp=0", {s_cnt_mid, s_cnt_high, s_cnt_inval});
    end
    @(posedge clk); #1; s_start = 1'b1; s_codes = 8'h21;
    @(posedge clk); #1; s_start = 1'b0; s_clr = 1'b1;
    @(posedge clk); #1; s_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_cls_valid !== 1'b1) begin n_fail++; $display("FAIL sat_clr_scan cls_valid got=%b exp=1", s_cls_valid); end
    n_cmp++; if (s_cnt_low !== 2'd0) begin n_fail++; $display("FAIL sat_clr_win got=%0d exp=0", s_cnt_low); end
    @(posedge clk); #1;
    sat_wait_done();
    n_cmp++; if (s_cnt_low !== 2'd1) begin n_fail++; $display("FAIL sat_after_clr got=%0d exp=1", s_cnt_low); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_boundary();
    test_snapshot();
    test_abort();
    test_start_held();
    test_rst_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
